imm_gen_pipe: RTL and testbench

Parametrised, two-stage pipelined immediate generator with valid/ready flow control.
- Stage 1 decodes the instruction format and extracts the sign-extended immediate at XLEN width.
- Stage 2 computes the PC-relative target (pc + imm) for JAL, BRANCH and AUIPC.
- Sits between fetch and decode/branch-resolution; replaces the combinational immediate generator in the pipelined core.

---
 rtl/imm_gen_pipe.sv | 186 ++++++++++++++++++
 tb/tb_imm_gen_pipe.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// Two-stage pipelined immediate generator with valid/ready flow control.
// Optional CSR-immediate (format Z) decode is enabled by defining IMM_GEN_CSR_EN.
module imm_gen_pipe #(
  parameter int XLEN       = 32,
  parameter bit PASS_INSTR = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_target_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_instr
);

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OPIMM    = 7'b0010011;
  localparam logic [6:0] OP_OPIMM32  = 7'b0011011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_OP32     = 7'b0111011;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;
  localparam logic [2:0] FMT_Z = 3'd5;
  localparam logic [2:0] FMT_R = 3'd6;
  localparam logic [2:0] FMT_X = 3'd7;

  logic [2:0]      dec_fmt_s;
  logic [31:0]     dec_imm32_s;
  logic [XLEN-1:0] dec_imm_s;
  logic            dec_tv_s;
  logic            s2_adv_s;

  logic            s1_valid_r;
  logic [2:0]      s1_fmt_r;
  logic [XLEN-1:0] s1_imm_r;
  logic            s1_tv_r;
  logic [XLEN-1:0] s1_pc_r;
  logic [31:0]     s1_instr_r;

  logic            out_valid_r;
  logic [2:0]      out_fmt_r;
  logic [XLEN-1:0] out_imm_r;
  logic [XLEN-1:0] out_target_r;
  logic            out_tv_r;
  logic [XLEN-1:0] out_pc_r;
  logic [31:0]     out_instr_r;

  // Format decode and 32-bit immediate extraction, then sign extension to XLEN.
  always_comb begin
    dec_fmt_s   = FMT_X;
    dec_tv_s    = 1'b0;
    dec_imm32_s = {{20{in_instr[31]}}, in_instr[31:20]};
    case (in_instr[6:0])
      OP_LUI: begin
        dec_fmt_s   = FMT_U;
        dec_imm32_s = {in_instr[31:12], 12'd0};
      end
      OP_AUIPC: begin
        dec_fmt_s   = FMT_U;
        dec_tv_s    = 1'b1;
        dec_imm32_s = {in_instr[31:12], 12'd0};
      end
      OP_JAL: begin
        dec_fmt_s   = FMT_J;
        dec_tv_s    = 1'b1;
        dec_imm32_s = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                       in_instr[20], in_instr[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_OPIMM, OP_OPIMM32: begin
        dec_fmt_s = FMT_I;
      end
      OP_BRANCH: begin
        dec_fmt_s   = FMT_B;
        dec_tv_s    = 1'b1;
        dec_imm32_s = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                       in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OP_STORE: begin
        dec_fmt_s   = FMT_S;
        dec_imm32_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_OP, OP_OP32: begin
        dec_fmt_s   = FMT_R;
        dec_imm32_s = 32'd0;
      end
      OP_SYSTEM: begin
`ifdef IMM_GEN_CSR_EN
        // CSRR*I carries a 5-bit unsigned immediate in the rs1 field
        if (in_instr[14:12] == 3'b101 || in_instr[14:12] == 3'b110 ||
            in_instr[14:12] == 3'b111) begin
          dec_fmt_s   = FMT_Z;
          dec_imm32_s = {27'd0, in_instr[19:15]};
        end else begin
          dec_fmt_s = FMT_I;
        end
`else
        dec_fmt_s = FMT_I;
`endif
      end
      default: begin
        dec_fmt_s = FMT_X;
      end
    endcase
    dec_imm_s        = {XLEN{dec_imm32_s[31]}};
    dec_imm_s[31:0]  = dec_imm32_s;
  end

  assign s2_adv_s = !out_valid_r || out_ready;
  assign in_ready = !s1_valid_r || s2_adv_s;

  // Stage 1: capture decoded immediate, format and PC.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      s1_fmt_r   <= FMT_X;
      s1_imm_r   <= '0;
      s1_tv_r    <= 1'b0;
      s1_pc_r    <= '0;
      s1_instr_r <= 32'd0;
    end else if (flush) begin
      s1_valid_r <= 1'b0;
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_fmt_r   <= dec_fmt_s;
        s1_imm_r   <= dec_imm_s;
        s1_tv_r    <= dec_tv_s;
        s1_pc_r    <= in_pc;
        s1_instr_r <= in_instr;
      end
    end
  end

  // Stage 2: PC-relative target and registered outputs; holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r  <= 1'b0;
      out_fmt_r    <= FMT_X;
      out_imm_r    <= '0;
      out_target_r <= '0;
      out_tv_r     <= 1'b0;
      out_pc_r     <= '0;
      out_instr_r  <= 32'd0;
    end else if (flush) begin
      out_valid_r <= 1'b0;
    end else if (s2_adv_s) begin
      out_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        out_fmt_r    <= s1_fmt_r;
        out_imm_r    <= s1_imm_r;
        out_target_r <= s1_pc_r + s1_imm_r;
        out_tv_r     <= s1_tv_r;
        out_pc_r     <= s1_pc_r;
        out_instr_r  <= PASS_INSTR ? s1_instr_r : 32'd0;
      end
    end
  end

  assign out_valid        = out_valid_r;
  assign out_fmt          = out_fmt_r;
  assign out_imm          = out_imm_r;
  assign out_target       = out_target_r;
  assign out_target_valid = out_tv_r;
  assign out_pc           = out_pc_r;
  assign out_instr        = out_instr_r;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [63:0] in_pc64;

  logic        in_ready32, out_valid32, out_tv32;
  logic [31:0] out_imm32, out_target32, out_pc32, out_instr32;
  logic [2:0]  out_fmt32;

  logic        in_ready64, out_valid64, out_tv64;
  logic [63:0] out_imm64, out_target64, out_pc64;
  logic [31:0] out_instr64;
  logic [2:0]  out_fmt64;

  int checks = 0;
  int errors = 0;

  assign in_pc64 = {32'd0, in_pc};

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .PASS_INSTR(1'b1)) dut32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32),
    .out_target(out_target32), .out_target_valid(out_tv32),
    .out_pc(out_pc32), .out_instr(out_instr32)
  );

  imm_gen_pipe #(.XLEN(64), .PASS_INSTR(1'b0)) dut64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_target(out_target64), .out_target_valid(out_tv64),
    .out_pc(out_pc64), .out_instr(out_instr64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Offer one instruction for one cycle; returns at the negedge after it was accepted.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    @(negedge clk);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run1(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                      input logic [63:0] e_imm, input logic [2:0] e_fmt,
                      input logic [63:0] e_tgt, input logic e_tv);
    issue(instr, pc);
    chk({tag, "_early"}, {63'd0, out_valid32}, 64'd0);
    @(negedge clk);
    chk({tag, "_valid"}, {63'd0, out_valid32}, 64'd1);
    chk({tag, "_imm"},   {32'd0, out_imm32}, e_imm);
    chk({tag, "_fmt"},   {61'd0, out_fmt32}, {61'd0, e_fmt});
    chk({tag, "_tgt"},   {32'd0, out_target32}, e_tgt);
    chk({tag, "_tv"},    {63'd0, out_tv32}, {63'd0, e_tv});
    chk({tag, "_pc"},    {32'd0, out_pc32}, {32'd0, pc});
    chk({tag, "_instr"}, {32'd0, out_instr32}, {32'd0, instr});
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_instr  = 32'd0;
    in_pc     = 32'd0;

    // Reset state
    #2;
    chk("rst_out_valid", {63'd0, out_valid32}, 64'd0);
    chk("rst_out_fmt",   {61'd0, out_fmt32}, 64'd7);
    chk("rst_out_imm",   {32'd0, out_imm32}, 64'd0);
    chk("rst_out_tgt",   {32'd0, out_target32}, 64'd0);
    chk("rst_out_tv",    {63'd0, out_tv32}, 64'd0);
    chk("rst_out_pc",    {32'd0, out_pc32}, 64'd0);
    chk("rst_out_instr", {32'd0, out_instr32}, 64'd0);
    chk("rst_in_ready",  {63'd0, in_ready32}, 64'd1);
    chk("rst_fmt64",     {61'd0, out_fmt64}, 64'd7);
    @(negedge clk);
    rst = 1'b0;

    // Format coverage at XLEN=32
    run1("jal",    32'h008000EF, 32'h00000100, 64'h8, 3'd4, 64'h108, 1'b1);
    run1("beq",    32'hFE000EE3, 32'h00000200, 64'hFFFFFFFC, 3'd2, 64'h1FC, 1'b1);
    chk("beq64_imm", out_imm64, 64'hFFFFFFFFFFFFFFFC);
    chk("beq64_fmt", {61'd0, out_fmt64}, 64'd2);
    chk("beq64_tgt", out_target64, 64'h1FC);
    chk("beq64_tv",  {63'd0, out_tv64}, 64'd1);
    chk("beq64_instr_tied", {32'd0, out_instr64}, 64'd0);
    run1("lui",    32'h800002B7, 32'h00000204, 64'h80000000, 3'd3, 64'h80000204, 1'b0);
    chk("lui64_imm", out_imm64, 64'hFFFFFFFF80000000);
    chk("lui64_fmt", {61'd0, out_fmt64}, 64'd3);
    chk("lui64_tv",  {63'd0, out_tv64}, 64'd0);
    run1("auipc",  32'h00001517, 32'h00000300, 64'h1000, 3'd3, 64'h1300, 1'b1);
    run1("store",  32'hFE512E23, 32'h00000308, 64'hFFFFFFFC, 3'd1, 64'h304, 1'b0);
    run1("addi",   32'hFFF00093, 32'h00000310, 64'hFFFFFFFF, 3'd0, 64'h30F, 1'b0);
    run1("add",    32'h00208033, 32'h00000314, 64'h0, 3'd6, 64'h314, 1'b0);
    run1("unk",    32'h7FF0007F, 32'h00000318, 64'h7FF, 3'd7, 64'hB17, 1'b0);
    run1("jalr",   32'h00008067, 32'h0000031C, 64'h0, 3'd0, 64'h31C, 1'b0);
    run1("wrap",   32'h008000EF, 32'hFFFFFFFC, 64'h8, 3'd4, 64'h4, 1'b1);
    chk("wrap64_tgt", out_target64, 64'h100000004);
`ifdef IMM_GEN_CSR_EN
    run1("csrrwi", 32'h34015073, 32'h00000320, 64'h2, 3'd5, 64'h322, 1'b0);
`else
    run1("csrrwi", 32'h34015073, 32'h00000320, 64'h340, 3'd0, 64'h660, 1'b0);
`endif

    // Backpressure: three ADDIs (imm 1,2,3) with out_ready low
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    in_pc     = 32'h00000400;
    @(negedge clk);
    chk("bp_ready_1st", {63'd0, in_ready32}, 64'd1);
    in_instr = 32'h00200093;
    in_pc    = 32'h00000404;
    @(negedge clk);
    chk("bp_ready_low", {63'd0, in_ready32}, 64'd0);
    chk("bp_valid",     {63'd0, out_valid32}, 64'd1);
    in_instr = 32'h00300093;
    in_pc    = 32'h00000408;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", {63'd0, out_valid32}, 64'd1);
      chk("bp_hold_imm",   {32'd0, out_imm32}, 64'd1);
      chk("bp_hold_pc",    {32'd0, out_pc32}, 64'h400);
      chk("bp_hold_ready", {63'd0, in_ready32}, 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", {63'd0, in_ready32}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_imm", {32'd0, out_imm32}, 64'd2);
    chk("bp_second_pc",  {32'd0, out_pc32}, 64'h404);
    @(negedge clk);
    chk("bp_third_valid", {63'd0, out_valid32}, 64'd1);
    chk("bp_third_imm",   {32'd0, out_imm32}, 64'd3);
    @(negedge clk);
    chk("bp_drained", {63'd0, out_valid32}, 64'd0);

    // Flush with both stages full and a new instruction offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00400093;
    in_pc     = 32'h00000500;
    @(negedge clk);
    in_instr = 32'h00500093;
    in_pc    = 32'h00000504;
    @(negedge clk);
    chk("fl_full_valid", {63'd0, out_valid32}, 64'd1);
    chk("fl_full_imm",   {32'd0, out_imm32}, 64'd4);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_instr  = 32'h00600093;
    in_pc     = 32'h00000508;
    #1;
    chk("fl_in_ready", {63'd0, in_ready32}, 64'd1);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_out_cleared", {63'd0, out_valid32}, 64'd0);
    chk("fl_out_cleared64", {63'd0, out_valid64}, 64'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("fl_dropped", {63'd0, out_valid32}, 64'd0);
    end

    // Asynchronous reset while stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00700093;
    in_pc     = 32'h00000600;
    @(negedge clk);
    in_instr = 32'h00800093;
    in_pc    = 32'h00000604;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar_stalled_valid", {63'd0, out_valid32}, 64'd1);
    chk("ar_stalled_ready", {63'd0, in_ready32}, 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_valid_clear", {63'd0, out_valid32}, 64'd0);
    chk("ar_ready_set",   {63'd0, in_ready32}, 64'd1);
    chk("ar_fmt",         {61'd0, out_fmt32}, 64'd7);
    chk("ar_imm",         {32'd0, out_imm32}, 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    run1("ar_after", 32'h00900093, 32'h00000700, 64'h9, 3'd0, 64'h709, 1'b0);
    @(negedge clk);
    chk("ar_no_extra", {63'd0, out_valid32}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
